// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver and its consumer.
// The master drives data/valid and the slave acknowledges with ready.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, 8 data bits, one stop bit.
// Define UART_RX_PARITY_EN to add one even-parity bit after bit 7.
module uart_rx (
  input  logic      clk,
  input  logic      rst,
  input  logic      tick,
  input  logic      rx,
  uart_rx_if.master bus,
  output logic      frame_err,
  output logic      overrun,
  output logic      parity_err
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t     state, state_d;
  logic [3:0] s_cnt, s_cnt_d;
  logic [2:0] n, n_d;
  logic [7:0] sh, sh_d;
  logic       brk, brk_d;
  logic       rx_m, rx_s;
  logic       good, bad_stop;
`ifdef UART_RX_PARITY_EN
  logic       par, par_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s_cnt <= 4'd0;
      n     <= 3'd0;
      sh    <= 8'h00;
      brk   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_d;
      s_cnt <= s_cnt_d;
      n     <= n_d;
      sh    <= sh_d;
      brk   <= brk_d;
`ifdef UART_RX_PARITY_EN
      par   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d  = state;
    s_cnt_d  = s_cnt;
    n_d      = n;
    sh_d     = sh;
    brk_d    = brk;
    good     = 1'b0;
    bad_stop = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par;
`endif
    if (tick) begin
      unique case (state)
        IDLE: begin
          // after a framing error the line must go high before a new start
          if (brk) begin
            if (rx_s) brk_d = 1'b0;
          end else if (!rx_s) begin
            state_d = START;
            s_cnt_d = 4'd0;
          end
        end
        START: begin
          if (s_cnt == 4'd7) begin
            s_cnt_d = 4'd0;
            if (!rx_s) begin
              state_d = DATA;
              n_d     = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt + 4'd1;
          end
        end
        DATA: begin
          if (s_cnt == 4'd15) begin
            s_cnt_d = 4'd0;
            sh_d    = {rx_s, sh[7:1]};
            n_d     = n + 3'd1;
            if (n == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            s_cnt_d = s_cnt + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_cnt == 4'd15) begin
            s_cnt_d = 4'd0;
            par_d   = rx_s;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt + 4'd1;
          end
        end
`endif
        STOP: begin
          if (s_cnt == 4'd15) begin
            s_cnt_d = 4'd0;
            state_d = IDLE;
            if (rx_s) begin
              good = 1'b1;
            end else begin
              bad_stop = 1'b1;
              brk_d    = 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rx_data  <= 8'h00;
      bus.rx_valid <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= good & bus.rx_valid & ~bus.rx_ready;
      if (good) begin
        bus.rx_data  <= sh;
        bus.rx_valid <= 1'b1;
      end else if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= good & (^sh ^ par);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
